// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared fetch-stage types, constants and jump-target helper
package pc_fetch_unit_pkg;
    typedef enum logic [1:0] {RST, FETCH, HOLD} fetch_state_t;
    localparam logic [31:0] NOP_INSTN = 32'h0000_0000;
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4, input logic [25:0] field);
        return (pc_plus4 & 32'hF000_0000) | {4'b0, field, 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_unit_next_mux.sv
// pc_next_mux: selects the next pc from branch, jump, sequential or hold
module pc_next_mux
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] currpc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_in,
    input  logic [25:0] jump_address,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic        redirect
);
    logic [31:0] target;
    assign redirect = branch_taken | jump_in;
    assign target = branch_taken ? (branch_target & ~32'h3) : jump_target(currpc_plus4, jump_address);
    assign next_pc = redirect ? target : advance ? pc + 32'd4 : pc;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the pc, handshakes with imem and presents instructions to IF/ID
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTN = pc_fetch_unit_pkg::NOP_INSTN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_in,
    input  logic [25:0] jump_address,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] currpc,
    output logic [31:0] nextpc,
    output logic [31:0] inp_instn,
    output logic        instn_valid
);
    import pc_fetch_unit_pkg::*;
    fetch_state_t state;
    logic [31:0] pc, next_pc;
    logic redirect, advance;
    assign imem_addr = pc;
    assign nextpc = currpc + 32'd4;
    assign advance = !stall && (state == HOLD || (state == FETCH && imem_ready));
    pc_next_mux u_mux (
        .pc(pc),
        .currpc_plus4(nextpc),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump_in(jump_in),
        .jump_address(jump_address),
        .advance(advance),
        .next_pc(next_pc),
        .redirect(redirect)
    );
    // Leaving HOLD presents a bubble so the released word is not captured twice
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST;
            pc <= RESET_PC;
            currpc <= RESET_PC;
            inp_instn <= NOP_INSTN;
            instn_valid <= 1'b0;
            imem_req <= 1'b0;
        end else if (state == RST) begin
            state <= FETCH;
            imem_req <= 1'b1;
        end else begin
            pc <= next_pc;
            if (redirect) begin
                state <= FETCH;
                imem_req <= 1'b1;
                inp_instn <= NOP_INSTN;
                instn_valid <= 1'b0;
            end else if (state == FETCH) begin
                if (imem_ready) begin
                    inp_instn <= imem_rdata;
                    currpc <= pc;
                    instn_valid <= 1'b1;
                    if (stall) begin
                        state <= HOLD;
                        imem_req <= 1'b0;
                    end
                end else begin
                    inp_instn <= NOP_INSTN;
                    instn_valid <= 1'b0;
                end
            end else if (!stall) begin
                state <= FETCH;
                imem_req <= 1'b1;
                inp_instn <= NOP_INSTN;
                instn_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for pc_fetch_unit with an addr-echo memory
module tb_pc_fetch_unit;
    logic clk = 0, reset = 1, stall = 0, jump_in = 0, branch_taken = 0, imem_ready = 1;
    logic [25:0] jump_address = '0;
    logic [31:0] branch_target = '0;
    logic imem_req, instn_valid;
    logic [31:0] imem_addr, imem_rdata, currpc, nextpc, inp_instn;
    int vectors = 0, miscompares = 0;
    assign imem_rdata = imem_addr;
    always #5 clk = ~clk;
    pc_fetch_unit #(.RESET_PC(32'h100), .NOP_INSTN(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump_in(jump_in), .jump_address(jump_address),
        .branch_taken(branch_taken), .branch_target(branch_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .currpc(currpc), .nextpc(nextpc), .inp_instn(inp_instn), .instn_valid(instn_valid)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic out(input string tag, input logic [31:0] pcv, input logic v);
        check({tag, " currpc"}, currpc, pcv);
        check({tag, " nextpc"}, nextpc, pcv + 32'd4);
        check({tag, " instn"}, inp_instn, v ? pcv : 32'h0);
        check({tag, " valid"}, {31'b0, instn_valid}, {31'b0, v});
    endtask
    initial begin
        step();
        step();
        out("reset", 32'h100, 0);
        check("reset req", {31'b0, imem_req}, 0);
        check("reset addr", imem_addr, 32'h100);
        reset = 0;
        #1 check("rst state req", {31'b0, imem_req}, 0);
        step();
        check("first req", {31'b0, imem_req}, 1);
        check("first addr", imem_addr, 32'h100);
        check("first valid", {31'b0, instn_valid}, 0);
        step(); out("i100", 32'h100, 1);
        step(); out("i104", 32'h104, 1);
        stall = 1;
        step(); out("i108", 32'h108, 1);
        check("hold req", {31'b0, imem_req}, 0);
        step(); out("held", 32'h108, 1);
        check("held req", {31'b0, imem_req}, 0);
        check("held addr", imem_addr, 32'h108);
        stall = 0;
        step();
        check("release req", {31'b0, imem_req}, 1);
        check("release addr", imem_addr, 32'h10C);
        check("release valid", {31'b0, instn_valid}, 0);
        step(); out("i10c", 32'h10C, 1);
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait valid", {31'b0, instn_valid}, 0);
            check("wait instn", inp_instn, 32'h0);
            check("wait addr", imem_addr, 32'h110);
            check("wait req", {31'b0, imem_req}, 1);
        end
        imem_ready = 1;
        step(); out("i110", 32'h110, 1);
        check("i110 addr", imem_addr, 32'h114);
        branch_taken = 1; branch_target = 32'h203; jump_in = 1; jump_address = 26'h3FF;
        step();
        check("bj valid", {31'b0, instn_valid}, 0);
        check("bj instn", inp_instn, 32'h0);
        check("bj addr", imem_addr, 32'h200);
        branch_taken = 0; jump_in = 0;
        step(); out("i200", 32'h200, 1);
        branch_taken = 1; branch_target = 32'h1000_000C;
        step();
        check("br addr", imem_addr, 32'h1000_000C);
        branch_taken = 0;
        step(); out("ij", 32'h1000_000C, 1);
        jump_in = 1; jump_address = 26'h40;
        step();
        check("jmp valid", {31'b0, instn_valid}, 0);
        check("jmp addr", imem_addr, 32'h1000_0100);
        jump_in = 0;
        step(); out("jt", 32'h1000_0100, 1);
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        step();
        check("wrap addr0", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 0;
        step(); out("wrap", 32'hFFFF_FFFC, 1);
        check("wrap addr", imem_addr, 32'h0);
        step(); out("i0", 32'h0, 1);
        imem_ready = 0;
        step();
        check("pre-rst valid", {31'b0, instn_valid}, 0);
        #2 reset = 1;
        #1 out("async rst", 32'h100, 0);
        check("async rst req", {31'b0, imem_req}, 0);
        check("async rst addr", imem_addr, 32'h100);
        imem_ready = 1;
        step(); out("late ready", 32'h100, 0);
        check("late ready req", {31'b0, imem_req}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives a request/ready handshake to instruction memory. It applies jump and branch redirects and presents the fetched instruction with its PC and PC+4 for capture into IF/ID. It inserts NOP bubbles on memory wait states, stalls and redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTN, 32'h0000_0000, instruction word driven when no valid instruction is presented.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold the PC and the presented instruction.
- jump_in  in  1  jump decoded in ID (IF/ID jump_out).
- jump_address  in  26  jump field from ID.
- branch_taken  in  1  branch resolved taken.
- branch_target  in  32  branch destination.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_rdata  in  32  instruction word, valid when imem_ready.
- imem_ready  in  1  memory completes the outstanding request this cycle.
- currpc  out  32  PC of the presented instruction.
- nextpc  out  32  currpc + 4.
- inp_instn  out  32  presented instruction word (NOP_INSTN when invalid).
- instn_valid  out  1  presented word is a real instruction.

## Operation
- State machine with three states:
  - RST: entered on reset; advances to FETCH after the first clock edge.
  - FETCH: imem_req=1.
  - HOLD: an instruction is presented and stall is high; imem_req=0.
- Redirect target selection, in priority order:
  - branch_taken: target = branch_target.
  - else jump_in: target = {currpc_plus4[31:28], jump_address, 2'b00}, where currpc_plus4 is the nextpc output.
  - Redirect = branch_taken | jump_in.
- FETCH, on a clock edge with imem_ready=1, redirect=0, stall=0:
  - Capture inp_instn=imem_rdata, currpc=pc, nextpc=pc+4, instn_valid=1.
  - Update pc=pc+4.
- FETCH with imem_ready=0: present NOP (instn_valid=0); pc and request held.
- FETCH with imem_ready=1 and stall=1: capture the instruction as above and go to HOLD. pc is not advanced until the stall releases.
- HOLD: outputs frozen. When stall drops, update pc=pc+4 and return to FETCH.
- Any redirect, in any non-RST state:
  - pc=target.
  - Present NOP (instn_valid=0).
  - Discard the in-flight returned word, even if imem_ready=1 that cycle.
  - Go to FETCH. Redirect overrides stall.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of pc are always 0; branch_target[1:0] is forced to 0.

## Timing
- Reset values:
  - pc=RESET_PC.
  - currpc=RESET_PC, nextpc=RESET_PC+4.
  - inp_instn=NOP_INSTN, instn_valid=0.
  - imem_req=0, state RST.
- First imem_req is asserted in the cycle after reset deasserts.
- Latency with zero-wait memory: address presented in cycle N, instruction on the outputs after edge N+1. Throughput is 1 instruction per cycle.
- Redirect penalty: 1 bubble plus memory latency at the target.
- Reset asserted mid-fetch: immediately return to the reset values. Any late imem_ready is ignored.

## Structure
- Shared package holds:
  - The state enum {RST, FETCH, HOLD}.
  - The NOP_INSTN constant.
  - A function computing the jump target from PC+4 and the 26-bit field.
- One sub-module, pc_next_mux: combinational selection of branch / jump / sequential / hold.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning addr as data -> first valid outputs currpc=0x100, nextpc=0x104, inp_instn=0x100, followed by 0x104 and 0x108 on consecutive cycles.
- imem_ready low for 3 cycles at 0x104 -> 3 NOP outputs with instn_valid=0, then 0x104 presented, pc unchanged during the wait.
- stall high 2 cycles while 0x108 is presented -> outputs frozen 2 cycles, imem_req=0; then 0x10C fetched.
- jump_in=1 with jump_address=0x40 and nextpc=0x1000_0010 -> one bubble, next fetch address 0x1000_0100.
- branch_taken (target 0x200) and jump_in in the same cycle, with imem_ready=1 -> returned word discarded, next fetch address 0x200.
- pc=0xFFFF_FFFC fetched -> next pc 0x0; reset pulsed during a wait state -> outputs return to reset values immediately.
